// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin arbiter sharing one 8-digit seven-segment display between three
// requesters. Each grant is held for at least DWELL cycles while others are
// waiting. A requester that drops its request releases the display at once.
// When nobody requests, IDLE_WORD is shown.
//
// Ports:
//   clk_axi_i       system clock, rising edge
//   reset_i         synchronous active-high reset
//   req_i[2:0]      level-sensitive requests
//   data0_i..2_i    32-bit display words of requesters 0..2
//   grant_o[2:0]    one-hot grant, 3'b000 when idle
//   disp_word_o     word for the display driver's F input
//   disp_valid_o    high while a grant is active
//   switch_pulse_o  one-cycle pulse on every change of grant_o
//
// state | meaning
// IDLE  | nobody granted, IDLE_WORD shown
// HOLD  | requester cur_q owns the display, dwell counter running
module seg_display_arbiter #(
    parameter logic [31:0] DWELL     = 32'd100_000_000,
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
    input  logic        clk_axi_i,
    input  logic        reset_i,
    input  logic [2:0]  req_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [2:0]  grant_o,
    output logic [31:0] disp_word_o,
    output logic        disp_valid_o,
    output logic        switch_pulse_o
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_HOLD    = 1'b1;
    localparam logic [31:0] DWELL_LAST = DWELL - 32'd1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  grant_q, grant_d;
    logic [31:0] disp_word_q, disp_word_d;
    logic        disp_valid_q, disp_valid_d;
    logic        switch_pulse_q, switch_pulse_d;

    logic [2:0]  pick_all;
    logic [2:0]  pick_other;
    logic [2:0]  others;
    logic        cur_req;
    logic        dwell_done;

    // Returns {found, index}: first requesting index after 'last', wrapping
    // mod 3, optionally skipping 'excl'.
    function automatic logic [2:0] rr_pick(input logic [2:0] r_req,
                                           input logic [1:0] last,
                                           input logic       excl_en,
                                           input logic [1:0] excl);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!res[2] && r_req[idx] && !(excl_en && (idx == excl))) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick_all   = rr_pick(req_i, last_q, 1'b0, cur_q);
        pick_other = rr_pick(req_i, last_q, 1'b1, cur_q);
        others     = req_i & ~(3'b001 << cur_q);
        cur_req    = req_i[cur_q];
        dwell_done = (cnt_q == DWELL_LAST);

        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_all[2]) begin
                    state_d = ST_HOLD;
                    cur_d   = pick_all[1:0];
                    last_d  = pick_all[1:0];
                    cnt_d   = 32'd0;
                end
            end
            default: begin
                // Release wins over dwell expiry; both select the same pick
                // because the releasing requester is not asking any more.
                if (!cur_req) begin
                    if (|others) begin
                        cur_d  = pick_other[1:0];
                        last_d = pick_other[1:0];
                    end else begin
                        state_d = ST_IDLE;
                        last_d  = cur_q;
                    end
                    cnt_d = 32'd0;
                end else if (dwell_done && (|others)) begin
                    cur_d  = pick_other[1:0];
                    last_d = pick_other[1:0];
                    cnt_d  = 32'd0;
                end else if (!dwell_done) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase

        grant_d     = (state_d == ST_HOLD) ? (3'b001 << cur_d) : 3'b000;
        disp_word_d = IDLE_WORD;
        if (state_d == ST_HOLD) begin
            case (cur_d)
                2'd0:    disp_word_d = data0_i;
                2'd1:    disp_word_d = data1_i;
                default: disp_word_d = data2_i;
            endcase
        end
        disp_valid_d   = |grant_d;
        switch_pulse_d = (grant_d != grant_q);
    end

    always_ff @(posedge clk_axi_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            cur_q          <= 2'd0;
            last_q         <= 2'd2;
            cnt_q          <= 32'd0;
            grant_q        <= 3'b000;
            disp_word_q    <= IDLE_WORD;
            disp_valid_q   <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            disp_word_q    <= disp_word_d;
            disp_valid_q   <= disp_valid_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign grant_o        = grant_q;
    assign disp_word_o    = disp_word_q;
    assign disp_valid_o   = disp_valid_q;
    assign switch_pulse_o = switch_pulse_q;

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin arbiter that shares the board's single 8-digit seven-segment display between three requesters, for example an AXI register, a switch snapshot and a debug counter. It sits directly in front of the hex display driver. It selects which requester's 32-bit word drives the driver's `F` input, and holds each grant for a minimum dwell time so the readout stays legible. When nobody requests, it supplies a fixed idle word.

## Interface
- `DWELL`, default 100_000_000: minimum grant length in `clk_axi` cycles. Legal range is 1..2^32-1; the default gives 1 s at 100 MHz.
- `IDLE_WORD`, default 32'h0000_0000: value of `disp_word` while no requester is granted.
- `clk_axi`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  request per requester; level-sensitive, held high while the requester wants the display.
- `data0`  in  32  display word of requester 0.
- `data1`  in  32  display word of requester 1.
- `data2`  in  32  display word of requester 2.
- `grant`  out  3  one-hot grant, or 3'b000 when idle.
- `disp_word`  out  32  word for the display driver's `F` input.
- `disp_valid`  out  1  high while a grant is active.
- `switch_pulse`  out  1  one-cycle pulse on every change of `grant`, including grant-to-idle and idle-to-grant.

## Operation
- **Reset.** The synchronous reset applies to every register at the next edge while `reset`=1, including when it occurs mid-grant. Reset values:
  - state IDLE, `grant`=0, `disp_valid`=0, `switch_pulse`=0;
  - `disp_word`=`IDLE_WORD`;
  - dwell counter = 0;
  - round-robin pointer `last`=2, so requester 0 wins first.
- **States.** There are two states, IDLE and HOLD. `cur` is the index of the granted requester.
- **Round-robin pick.** The pick is the first index with `req` set, scanning `last+1`, `last+2`, `last+3`, all mod 3. The pick excludes `cur` when the cause is a dwell expiry, but includes it from IDLE.
- **IDLE transitions:**
  - any `req` set → HOLD on the pick; the counter loads 0.
  - otherwise stay in IDLE.
- **HOLD transitions:**
  - `req[cur]`=0 and another `req` is set → switch to the pick immediately, ignoring dwell.
  - `req[cur]`=0 and no other `req` is set → IDLE.
  - `req[cur]`=1, dwell done and another `req` is set → switch to the pick (excluding `cur`).
  - `req[cur]`=1 and (dwell not done, or no other `req`) → stay; the counter keeps running.
- **Switch actions.** On every switch the counter loads 0 and `last` is updated to the new `cur`. The grant-to-IDLE transition also updates `last` to the index just released.
- **Dwell counter:**
  - 32-bit counter; increments by 1 per HOLD cycle and saturates at `DWELL-1`.
  - Dwell is done when the counter equals `DWELL-1`.
  - With `DWELL`=1, dwell is done in the first HOLD cycle.
- **Data path:**
  - `disp_word` is registered. In HOLD it is the value of `data[cur]` sampled at the previous edge, so data changes during a grant appear with 1-cycle latency.
  - In IDLE, `disp_word`=`IDLE_WORD`.
- **Outputs.** `disp_valid` equals `|grant`. `switch_pulse` is registered and high for exactly the cycle in which the new `grant` value first appears.
- **Invariants:** `grant` is one-hot or zero, and a requester with `req`=0 is never granted.

## Timing
- **Grant latency.** `req` is sampled at edge E; `grant`, `disp_word`, `disp_valid` and `switch_pulse` update after E. From a request to a visible grant takes 1 cycle.
- **Release latency.** `req[cur]` falling, sampled at edge E, frees the display after E. A new grant or IDLE appears in that same cycle, with no idle gap between grants.
- **Dwell under contention.** A grant lasts at least `DWELL` cycles: the first HOLD cycle has count 0, and a switch takes effect after the edge that samples count=`DWELL-1`.
- **Simultaneous events.** If a dwell expiry and `req[cur]` falling coincide, the release rule applies; the result is the same pick.
- **Simultaneous requests from IDLE.** The round-robin pointer decides.
- **Combinational paths.** No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset values and first grant.** Hold `reset`=1 for 3 cycles, then release with `req`=3'b000 → `grant`=0, `disp_word`=`IDLE_WORD`, `disp_valid`=0. Then raise `req`=3'b111 with `data0`=32'h1234_5678 → one cycle later `grant`=3'b001, `disp_word`=32'h1234_5678, `switch_pulse`=1 for one cycle.
- **Rotation with `DWELL`=4, `req`=3'b111 held.** Grants rotate 001→010→100→001, each exactly 4 cycles. `switch_pulse` fires once per change.
- **Early release with `DWELL`=4.** Grant is 0 and `req`=3'b101. Drop `req[0]` in the 2nd HOLD cycle → next cycle `grant`=3'b100, with no IDLE cycle.
- **Single requester beyond dwell, `DWELL`=4.** Only `req[1]` is high for 20 cycles → `grant` stays 3'b010 and `switch_pulse` stays 0 after the first pulse. Drop `req[1]` → `grant`=0, `disp_word`=`IDLE_WORD` and `switch_pulse`=1 for one cycle. Then raise `req`=3'b111 → next grant is 3'b100 (pointer follows `last`=1).
- **Data tracking.** During a grant to requester 2, change `data2` from 32'hAAAA_0000 to 32'h0000_BBBB → `disp_word` follows exactly 1 cycle later; `grant` is unchanged.
- **Mid-operation reset.** Assert `reset` for 1 cycle in the 3rd cycle of a grant to requester 1 → all outputs return to reset values at that edge. After release with `req`=3'b111, requester 0 is granted first.
